// File: rtl/ecb_e_iter_pkg.sv
// Shared AES-128 encrypt-side definitions: FSM encoding, forward S-box table,
// GF(2^8) helpers, round constants, MixColumns and the key-schedule step.
package ecb_e_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // sub_rot is SubWord(RotWord(w3)), computed by the caller's S-boxes.
    function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                    input logic [31:0]  sub_rot,
                                                    input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_rot ^ {rc, 24'h000000};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox
    import ecb_e_iter_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    // Byte a sits at bits {~a,3'b111} down to {~a,3'b000} of the table.
    assign y_o = SBOX_TABLE[{~a_i, 3'b111} -: 8];

endmodule

// File: rtl/ecb_e_iter.sv
// Iterative AES-128 ECB encryptor: one round per clock, valid/ready on both sides,
// key sampled together with each plaintext block.
module ecb_e_iter
    import ecb_e_iter_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] planetext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] image
);

    fsm_e         fsm_q;
    logic [127:0] st_q;
    logic [127:0] rk_q;
    logic [127:0] image_q;
    logic [3:0]   round_q;
    logic         out_valid_q;

    logic [127:0] sb, sr, mc;
    logic [127:0] st_d, rk_d;
    logic [31:0]  rot_w, sub_w;
    logic         last_round;

    for (genvar gi = 0; gi < 16; gi++) begin : g_sub_bytes
        aes_sbox u_sbox (
            .a_i (st_q[127-8*gi -: 8]),
            .y_o (sb[127-8*gi -: 8])
        );
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_shift_rows
        localparam int ROW = gi % 4;
        localparam int SRC = ROW + 4 * (((gi / 4) + ROW) % 4);
        assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix_cols
        assign mc[127-32*gi -: 32] = mix_col(sr[127-32*gi -: 32]);
    end

    assign rot_w = {rk_q[23:0], rk_q[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sub_word
        aes_sbox u_sbox (
            .a_i (rot_w[31-8*gi -: 8]),
            .y_o (sub_w[31-8*gi -: 8])
        );
    end

    assign last_round = (round_q == 4'(NR));
    assign rk_d       = next_round_key(rk_q, sub_w, rcon(round_q));
    assign st_d       = (last_round ? sr : mc) ^ rk_d;

    // The sink's ready is passed straight through in DONE so a finished block
    // can be drained and the next one loaded on the same edge.
    assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign image     = image_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            image_q     <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q    <= planetext ^ key;
                        rk_q    <= key;
                        round_q <= 4'd1;
                        fsm_q   <= ROUND;
                    end
                end
                ROUND: begin
                    rk_q <= rk_d;
                    if (last_round) begin
                        image_q     <= st_d;
                        out_valid_q <= 1'b1;
                        fsm_q       <= DONE;
                    end else begin
                        st_q    <= st_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            st_q    <= planetext ^ key;
                            rk_q    <= key;
                            round_q <= 4'd1;
                            fsm_q   <= ROUND;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecb_e_iter.sv
// Directed-vector bench for ecb_e_iter using FIPS-197 and SP800-38A known answers.
module tb_ecb_e_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] planetext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] image;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ecb_e_iter #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .planetext (planetext),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .image     (image)
    );

    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [127:0] sp_pt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                                128'hae2d8a571e03ac9c9eb76fac45af8e51,
                                128'h30c81c46a35ce411e5fbc1191a0a52ef,
                                128'hf69f2445df4f9b17ad2b417be66c3710};
    logic [127:0] sp_ct [4] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97,
                                128'hf5d3d58503b9699de785895a96fdbaaf,
                                128'h43b1cd7f598ece23881b00e3ed030688,
                                128'h7b0c785e27e8ad3f8223207104725dd4};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block from IDLE, measure accept-to-out_valid latency, then drain.
    task automatic encrypt(input string tag, input logic [127:0] k,
                           input logic [127:0] pt, input logic [127:0] exp);
        int guard;
        int cyc;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        in_valid  = 1'b1;
        planetext = pt;
        key       = k;
        tick();
        in_valid  = 1'b0;
        planetext = ~pt;
        key       = ~k;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq({tag, "_latency"}, 128'(cyc), 128'(10));
        check_eq({tag, "_ct"}, image, exp);
        $display("block %s: pt=%h ct=%h latency=%0d", tag, pt, image, cyc);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_drained"}, 128'({out_valid, in_ready}), 128'(2'b01));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        planetext = '0;
        key       = '0;
        tick();
        tick();
        check_eq("rst_out_valid", 128'(out_valid), 128'(0));
        check_eq("rst_in_ready", 128'(in_ready), 128'(1));
        check_eq("rst_image", image, 128'(0));
        rst = 1'b0;
        tick();

        encrypt("fips197_b", K_B, PT_B, CT_B);
        encrypt("fips197_c1", K_C1, PT_C1, CT_C1);

        // out_ready with nothing pending must not change anything
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("idle_out_ready", 128'({out_valid, in_ready}), 128'(2'b01));
        check_eq("idle_image_kept", image, CT_C1);

        // Four blocks back-to-back with an always-ready sink
        begin
            int in_idx;
            int out_idx;
            int cyc;
            in_idx    = 0;
            out_idx   = 0;
            cyc       = 0;
            key       = K_B;
            planetext = sp_pt[0];
            in_valid  = 1'b1;
            while (out_idx < 4 && cyc < 100) begin
                bit acc;
                acc = in_valid && in_ready;
                if (out_valid) begin
                    check_eq($sformatf("b2b_ct%0d", out_idx), image, sp_ct[out_idx]);
                    $display("block b2b%0d: ct=%h", out_idx, image);
                    if (in_idx < 4)
                        check_eq($sformatf("b2b_refill%0d", out_idx), 128'(in_ready), 128'(1));
                    out_idx++;
                end
                tick();
                cyc++;
                if (acc) begin
                    in_idx++;
                    if (in_idx < 4) planetext = sp_pt[in_idx];
                    else in_valid = 1'b0;
                end
            end
            check_eq("b2b_blocks_out", 128'(out_idx), 128'(4));
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end

        // Backpressure: output must hold while the sink stalls
        begin
            int guard;
            key       = K_B;
            planetext = PT_B;
            in_valid  = 1'b1;
            tick();
            in_valid = 1'b0;
            guard = 0;
            while (!out_valid && guard < 50) begin
                tick();
                guard++;
            end
            for (int i = 0; i < 20; i++) begin
                in_valid  = 1'($urandom_range(0, 1));
                planetext = {$urandom(), $urandom(), $urandom(), $urandom()};
                key       = {$urandom(), $urandom(), $urandom(), $urandom()};
                tick();
                check_eq($sformatf("bp_image%0d", i), image, CT_B);
                check_eq($sformatf("bp_flags%0d", i), 128'({out_valid, in_ready}), 128'(2'b10));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_eq("bp_release_flags", 128'({out_valid, in_ready}), 128'(2'b01));
            check_eq("bp_release_image", image, CT_B);
            $display("block backpressure: ct=%h held 20 cycles", image);
        end

        // Reset in the middle of round 5
        key       = K_C1;
        planetext = PT_C1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_eq("midrst_flags", 128'({out_valid, in_ready}), 128'(2'b01));
        check_eq("midrst_image", image, 128'(0));
        $display("block mid_reset: outputs cleared");
        tick();
        rst = 1'b0;
        tick();
        encrypt("after_reset", K_B, sp_pt[1], sp_ct[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
